// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline-stage constants and types
package pipe_pkg;

  localparam int IF_ID_W      = 96;
  localparam int INSTR_LSB    = 0;
  localparam int PC_PLUS4_LSB = 32;
  localparam int PC_LSB       = 64;

  localparam logic [31:0] NOP_WORD = 32'd0;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_PARTIAL,
    OCC_FULL
  } occ_e;

endpackage

// File: rtl/pipe_buf_storage.sv
// rtl/pipe_buf_storage.sv - DEPTH-entry register array, one write port, async read
module pipe_buf_storage #(
  parameter int DEPTH = 2,
  parameter int W     = 97,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - elastic pipeline stage register with valid/ready and flush
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W = IF_ID_W,
  parameter int TAG_W  = 1,
  parameter int DEPTH  = 2
) (
  input  logic                       cpu_clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [TAG_W-1:0]           out_tag,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  occ_e          occ;
  logic          push, pop;
  logic [TAG_W+DATA_W-1:0] head;

  always_comb begin
    occ = OCC_PARTIAL;
    if (count_q == '0)               occ = OCC_EMPTY;
    else if (count_q == CW'(DEPTH))  occ = OCC_FULL;
  end

  // Ready depends only on registered occupancy, so a full buffer never
  // accepts a word even if the head is popped on the same edge.
  assign in_ready  = (occ != OCC_FULL);
  assign out_valid = (occ != OCC_EMPTY);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(negedge cpu_clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  pipe_buf_storage #(
    .DEPTH (DEPTH),
    .W     (TAG_W + DATA_W),
    .AW    (AW)
  ) u_storage (
    .clk   (cpu_clk),
    .reset (reset),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata ({in_tag, in_data}),
    .raddr (rd_ptr_q),
    .rdata (head)
  );

  assign out_data = out_valid ? head[DATA_W-1:0] : '0;
  assign out_tag  = out_valid ? head[TAG_W+DATA_W-1:DATA_W] : '0;
  assign count    = count_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - directed self-checking bench for pipe_stage_buf
module tb_pipe_stage_buf;

  logic cpu_clk;
  logic reset;

  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [95:0] a_in_data, a_out_data;
  logic        a_in_tag, a_out_tag;
  logic [1:0]  a_count;

  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [15:0] b_in_data, b_out_data;
  logic        b_in_tag, b_out_tag;
  logic [2:0]  b_count;

  int errors = 0;
  int checks = 0;

  pipe_stage_buf #(.DATA_W(96), .TAG_W(1), .DEPTH(2)) u_d2 (
    .cpu_clk(cpu_clk), .reset(reset), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_tag(a_in_tag),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_tag(a_out_tag),
    .count(a_count)
  );

  pipe_stage_buf #(.DATA_W(16), .TAG_W(1), .DEPTH(4)) u_d4 (
    .cpu_clk(cpu_clk), .reset(reset), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_tag(b_out_tag),
    .count(b_count)
  );

  initial cpu_clk = 1'b1;
  always #5 cpu_clk = ~cpu_clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(negedge cpu_clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [1:0] cnt, input logic vld,
                       input logic rdy, input logic [95:0] data, input logic tg);
    chk({tag, "_count"}, 128'(a_count), 128'(cnt));
    chk({tag, "_valid"}, 128'(a_out_valid), 128'(vld));
    chk({tag, "_ready"}, 128'(a_in_ready), 128'(rdy));
    chk({tag, "_data"}, 128'(a_out_data), 128'(data));
    chk({tag, "_tag"}, 128'(a_out_tag), 128'(tg));
  endtask

  logic [16:0] q[$];
  int          pushed;
  logic        exp_push, exp_pop;

  initial begin
    reset = 1'b1;
    a_flush = 0; a_in_valid = 0; a_out_ready = 0; a_in_data = '0; a_in_tag = 0;
    b_flush = 0; b_in_valid = 0; b_out_ready = 0; b_in_data = '0; b_in_tag = 0;
    #2;
    chk_a("reset", 2'd0, 1'b0, 1'b1, 96'h0, 1'b0);
    #1 reset = 1'b0;

    // streaming: one word per edge, occupancy stays at one
    a_out_ready = 1; a_in_valid = 1; a_in_data = 96'h4; a_in_tag = 1;
    step; chk_a("s1", 2'd1, 1'b1, 1'b1, 96'h4, 1'b1);
    a_in_data = 96'h8; a_in_tag = 0;
    step; chk_a("s2", 2'd1, 1'b1, 1'b1, 96'h8, 1'b0);
    a_in_data = 96'hC; a_in_tag = 1;
    step; chk_a("s3", 2'd1, 1'b1, 1'b1, 96'hC, 1'b1);
    a_in_valid = 0;
    step; chk_a("s4", 2'd0, 1'b0, 1'b1, 96'h0, 1'b0);

    // backpressure: A, B fill the buffer, C is held upstream
    a_out_ready = 0; a_in_valid = 1; a_in_data = 96'hA; a_in_tag = 0;
    step; chk_a("b1", 2'd1, 1'b1, 1'b1, 96'hA, 1'b0);
    a_in_data = 96'hB; a_in_tag = 1;
    step; chk_a("b2", 2'd2, 1'b1, 1'b0, 96'hA, 1'b0);
    a_in_data = 96'hC; a_in_tag = 0;
    step; chk_a("b3", 2'd2, 1'b1, 1'b0, 96'hA, 1'b0);
    a_out_ready = 1;
    step; chk_a("b4_pop_only", 2'd1, 1'b1, 1'b1, 96'hB, 1'b1);
    step; chk_a("b5", 2'd1, 1'b1, 1'b1, 96'hC, 1'b0);
    a_in_valid = 0;
    step; chk_a("b6", 2'd0, 1'b0, 1'b1, 96'h0, 1'b0);

    // flush with a full buffer, concurrent push and pop
    a_out_ready = 0; a_in_valid = 1; a_in_data = 96'hD; a_in_tag = 1;
    step; a_in_data = 96'hE;
    step; chk_a("f0", 2'd2, 1'b1, 1'b0, 96'hD, 1'b1);
    a_flush = 1; a_out_ready = 1; a_in_data = 96'hF;
    step; chk_a("f1", 2'd0, 1'b0, 1'b1, 96'h0, 1'b0);
    a_flush = 0; a_in_valid = 0;
    step; chk_a("f2", 2'd0, 1'b0, 1'b1, 96'h0, 1'b0);

    // flush at count=1 drops a word that could otherwise be pushed
    a_in_valid = 1; a_in_data = 96'h11; a_out_ready = 0;
    step; a_flush = 1; a_in_data = 96'h22;
    step; chk_a("f3", 2'd0, 1'b0, 1'b1, 96'h0, 1'b0);
    a_flush = 0; a_in_valid = 0;
    step; chk_a("f4", 2'd0, 1'b0, 1'b1, 96'h0, 1'b0);

    // asynchronous reset with two entries held
    a_in_valid = 1; a_in_data = 96'h5A5A_0000_1234; a_in_tag = 1;
    step; a_in_data = 96'h77;
    step; chk_a("r0", 2'd2, 1'b1, 1'b0, 96'h5A5A_0000_1234, 1'b1);
    a_in_valid = 0;
    #2 reset = 1;
    #1 chk_a("r1", 2'd0, 1'b0, 1'b1, 96'h0, 1'b0);
    #1 reset = 0;
    a_in_valid = 1; a_in_data = 96'h99; a_in_tag = 0; a_out_ready = 0;
    step; chk_a("r2", 2'd1, 1'b1, 1'b1, 96'h99, 1'b0);
    a_in_valid = 0;

    // DEPTH=4 tag/wrap: scoreboard queue drives expectations
    pushed = 0;
    for (int s = 0; s < 40 && (pushed < 10 || q.size() != 0); s++) begin
      b_in_valid  = (pushed < 10);
      b_in_data   = 16'h100 + 16'(pushed);
      b_in_tag    = ~pushed[0];
      b_out_ready = s[0];
      exp_push = b_in_valid && (q.size() != 4);
      exp_pop  = b_out_ready && (q.size() != 0);
      step;
      if (exp_pop) void'(q.pop_front());
      if (exp_push) begin
        q.push_back({b_in_tag, b_in_data});
        pushed++;
      end
      chk("w_count", 128'(b_count), 128'(q.size()));
      chk("w_ready", 128'(b_in_ready), 128'(q.size() != 4));
      chk("w_valid", 128'(b_out_valid), 128'(q.size() != 0));
      if (q.size() != 0) begin
        chk("w_data", 128'(b_out_data), 128'(q[0][15:0]));
        chk("w_tag", 128'(b_out_tag), 128'(q[0][16]));
      end else begin
        chk("w_data0", 128'(b_out_data), 128'(0));
        chk("w_tag0", 128'(b_out_tag), 128'(0));
      end
    end
    chk("w_done", 128'((pushed == 10) && (q.size() == 0)), 128'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised pipeline stage register with valid/ready handshake and a DEPTH-entry elastic buffer, the generalised successor of the fixed IF/ID latch. It sits between adjacent pipeline stages (first use: fetch→decode, carrying {PC, PC+4, instruction}). It adds:
- backpressure without dropping the incoming word;
- occupancy reporting;
- a per-entry sideband tag (e.g. return-from-exception flag) that travels with its payload;
- flush that discards all buffered entries.

## Interface
Parameters:
- DATA_W, 96, payload width in bits; IF/ID packing is {pc[31:0], pc_plus4[31:0], instr[31:0]}.
- TAG_W, 1, sideband tag width.
- DEPTH, 2, buffer entries; power of two, ≥2.

Ports:
- cpu_clk  in  1  pipeline clock; all state updates on the falling edge.
- reset  in  1  reset, asynchronous, active-high.
- flush  in  1  discard all entries this edge.
- in_valid  in  1  upstream word present.
- in_ready  out  1  buffer can accept a word.
- in_data  in  DATA_W  upstream payload.
- in_tag  in  TAG_W  upstream sideband.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts head (low = downstream stall).
- out_data  out  DATA_W  head payload; all-zero (NOP bubble) when empty.
- out_tag  out  TAG_W  head tag; zero when empty.
- count  out  $clog2(DEPTH+1)  current occupancy.

## Operation
- push = in_valid & in_ready; pop = out_valid & out_ready; both are evaluated at the same falling edge.
- Storage is a circular buffer with a write pointer, a read pointer and count. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- in_ready = (count != DEPTH). It is combinational from registered count only; there is no combinational path from out_ready. When full, a same-edge pop does not allow a push.
- out_valid = (count != 0). out_data/out_tag come from the head entry when valid, and are forced to zero otherwise.
- Occupancy states are derived from count:
  - EMPTY (0): push → PARTIAL.
  - PARTIAL (1..DEPTH-1): push-only → +1; pop-only → -1; push and pop together → unchanged.
  - FULL (DEPTH): pop → PARTIAL.
- Tag is written and read with its payload entry and is never shared across entries.
- flush has priority over push and pop at the same edge. It sets pointers and count to 0, so out_valid is low after that edge. A concurrent push is dropped and a concurrent pop is not acknowledged.
- Reset (asynchronous): pointers, count and all storage entries are cleared. Outputs go immediately to out_valid=0, out_data=0, out_tag=0, count=0, in_ready=1. Reset asserted mid-transfer discards all content.
- in_data is not sampled when in_valid=0. Entry contents outside [rd_ptr, rd_ptr+count) are don't-care but are reset to zero.

## Timing
- Latency: a word pushed at falling edge k appears at out_data with out_valid=1 after edge k, and is poppable at edge k+1.
- Throughput: one word per cycle sustained when out_ready=1.
- Backpressure: with out_ready=0, up to DEPTH words are accepted, then in_ready deasserts after the edge that fills the last entry.
- Order: strictly FIFO. There is no bypass from in_data to out_data within the same cycle.
- count, in_ready and out_valid change only on falling edges or on reset assertion.

## Structure
- Shared package pipe_pkg holds:
  - IF_ID_W = 96 and the field offsets for pc / pc_plus4 / instr;
  - a NOP_WORD constant of 32'd0.
- Natural sub-module: pipe_buf_storage. It is a DEPTH×(DATA_W+TAG_W) register array with a write port (we, waddr, wdata), an async read port (raddr → rdata) and asynchronous clear on reset.
- The top level holds pointers, count, handshake logic and zero-forcing of outputs.

## Test plan
- Reset: assert reset mid-cycle with 2 entries held → out_valid=0, count=0, in_ready=1, out_data=0 immediately.
- Streaming: DEPTH=2, out_ready=1, push 0x…0004, 0x…0008, 0x…000C on consecutive edges → same order on out_data one edge later each; count stays 1.
- Backpressure: out_ready=0, push A, B, C → count=2, in_ready=0, C held upstream. Then raise out_ready → A, then B, then C accepted, with no loss or duplication.
- Simultaneous events:
  - count=1 with push and pop on the same edge → count stays 1, out_data switches to the new word.
  - count=DEPTH with pop and in_valid → only the pop occurs.
- Flush: count=2 with flush, in_valid=1 and out_ready=1 on the same edge → count=0, out_valid=0, out_data=0, the pushed word is absent afterwards.
- Tag/wrap: DEPTH=4, push 10 words with alternating in_tag 1/0 while out_ready toggles → every out_tag matches its payload across pointer wrap-around.
